// File: rtl/prod_accum.sv
// Frame accumulator for multiplier products: sums up to LEN products per frame and
// presents sum/count/overflow on a valid/ready handshake. Optional macro: PROD_ACCUM_SAT_EN.
module prod_accum #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int LEN    = 16,
   parameter int CNT_W  = $clog2(LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_r;
   state_t             state_nxt_s;
   logic [ACC_W-1:0]   acc_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               ovf_r;
   logic [ACC_W:0]     sum_s;
   logic               carry_s;
   logic [ACC_W-1:0]   acc_nxt_s;
   logic               accept_s;
   logic               release_s;
   logic               in_ready_s;
   logic               out_valid_s;

   // Widened add; the extra top bit is the carry out of the accumulator.
   always_comb begin
      sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
      carry_s = sum_s[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
      if (carry_s || ovf_r) begin
         acc_nxt_s = {ACC_W{1'b1}};
      end else begin
         acc_nxt_s = sum_s[ACC_W-1:0];
      end
`else
      acc_nxt_s = sum_s[ACC_W-1:0];
`endif
   end

   // Next-state and handshake decode, driven only by registered state plus qualifiers.
   always_comb begin
      state_nxt_s = state_r;
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      accept_s    = 1'b0;
      release_s   = 1'b0;
      case (state_r)
         ACCUM: begin
            in_ready_s = 1'b1;
            accept_s   = in_valid;
            if (in_valid && (in_last || (cnt_r == LAST_CNT))) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         HOLD: begin
            out_valid_s = 1'b1;
            release_s   = out_ready;
            if (out_ready) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = ACCUM;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Accumulator, product count and sticky overflow; cleared when the result is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (release_s) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (accept_s) begin
         acc_r <= acc_nxt_s;
         cnt_r <= cnt_r + CNT_ONE;
         ovf_r <= ovf_r | carry_s;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_sum   = acc_r;
   assign out_count = cnt_r;
   assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum: two instances (ACC_W=40 and ACC_W=33, both LEN=4).
module tb_prod_accum;

   logic        clk;
   logic        rst;

   logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
   logic [31:0] a_in_prod;
   logic [39:0] a_out_sum;
   logic [2:0]  a_out_count;

   logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
   logic [31:0] b_in_prod;
   logic [32:0] b_out_sum;
   logic [2:0]  b_out_count;

   int checks;
   int errors;

   logic [63:0] held_sum;
   logic [63:0] held_cnt;
   logic [63:0] exp_ovf_sum;

   prod_accum #(.PROD_W(32), .ACC_W(40), .LEN(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
      .out_count(a_out_count), .out_ovf(a_out_ovf)
   );

   prod_accum #(.PROD_W(32), .ACC_W(33), .LEN(4)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
      .out_count(b_out_count), .out_ovf(b_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive A's inputs across one rising edge; returns at the following falling edge.
   task automatic step_a(input logic v, input logic [31:0] p, input logic l, input logic r);
      a_in_valid  = v;
      a_in_prod   = p;
      a_in_last   = l;
      a_out_ready = r;
      @(negedge clk);
   endtask

   task automatic step_b(input logic v, input logic [31:0] p, input logic l, input logic r);
      b_in_valid  = v;
      b_in_prod   = p;
      b_in_last   = l;
      b_out_ready = r;
      @(negedge clk);
   endtask

   task automatic chk_a_idle(input string tag);
      chk({tag, "_in_ready"},  64'(a_in_ready),  64'd1);
      chk({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
      chk({tag, "_out_sum"},   64'(a_out_sum),   64'd0);
      chk({tag, "_out_count"}, 64'(a_out_count), 64'd0);
      chk({tag, "_out_ovf"},   64'(a_out_ovf),   64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_prod = 32'd0; a_in_last = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_prod = 32'd0; b_in_last = 1'b0; b_out_ready = 1'b0;
`ifdef PROD_ACCUM_SAT_EN
      exp_ovf_sum = 64'h1_FFFF_FFFF;
`else
      exp_ovf_sum = 64'h0_FFFF_FFFD;
`endif

      #12;
      chk_a_idle("reset_a");
      chk("reset_b_in_ready",  64'(b_in_ready),  64'd1);
      chk("reset_b_out_valid", 64'(b_out_valid), 64'd0);
      chk("reset_b_out_sum",   64'(b_out_sum),   64'd0);
      @(negedge clk);
      rst = 1'b0;

      // in_last without in_valid does nothing
      step_a(1'b0, 32'd9, 1'b1, 1'b0);
      chk_a_idle("last_no_valid");

      // Back-to-back frame closed by count
      step_a(1'b1, 32'd1, 1'b0, 1'b1);
      step_a(1'b1, 32'd2, 1'b0, 1'b1);
      step_a(1'b1, 32'd3, 1'b0, 1'b1);
      chk("b2b_not_yet_valid", 64'(a_out_valid), 64'd0);
      step_a(1'b1, 32'd4, 1'b0, 1'b1);
      chk("b2b_out_valid", 64'(a_out_valid), 64'd1);
      chk("b2b_in_ready",  64'(a_in_ready),  64'd0);
      chk("b2b_out_sum",   64'(a_out_sum),   64'd10);
      chk("b2b_out_count", 64'(a_out_count), 64'd4);
      chk("b2b_out_ovf",   64'(a_out_ovf),   64'd0);
      step_a(1'b0, 32'd0, 1'b0, 1'b1);
      chk_a_idle("b2b_after_hs");

      // Simultaneous close: in_last on the LEN-th product
      step_a(1'b1, 32'd1, 1'b0, 1'b0);
      step_a(1'b1, 32'd1, 1'b0, 1'b0);
      step_a(1'b1, 32'd1, 1'b0, 1'b0);
      step_a(1'b1, 32'd5, 1'b1, 1'b0);
      chk("simul_out_valid", 64'(a_out_valid), 64'd1);
      chk("simul_out_sum",   64'(a_out_sum),   64'd8);
      chk("simul_out_count", 64'(a_out_count), 64'd4);
      step_a(1'b0, 32'd0, 1'b0, 1'b1);
      chk("simul_after_hs_valid", 64'(a_out_valid), 64'd0);
      step_a(1'b0, 32'd0, 1'b0, 1'b1);
      chk("simul_no_dup_valid", 64'(a_out_valid), 64'd0);
      chk("simul_no_dup_count", 64'(a_out_count), 64'd0);

      // Early close on the 2nd product
      step_a(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      step_a(1'b1, 32'd1, 1'b1, 1'b0);
      chk("early_out_valid", 64'(a_out_valid), 64'd1);
      chk("early_out_sum",   64'(a_out_sum),   64'h1_0000_0000);
      chk("early_out_count", 64'(a_out_count), 64'd2);
      chk("early_out_ovf",   64'(a_out_ovf),   64'd0);

      // Backpressure: result held for 5 cycles while inputs keep offering
      held_sum = 64'h1_0000_0000;
      held_cnt = 64'd2;
      for (int i = 0; i < 5; i++) begin
         step_a(1'b1, 32'd99, 1'b0, 1'b0);
         chk("bp_in_ready",  64'(a_in_ready),  64'd0);
         chk("bp_out_valid", 64'(a_out_valid), 64'd1);
         chk("bp_out_sum",   64'(a_out_sum),   held_sum);
         chk("bp_out_count", 64'(a_out_count), held_cnt);
      end
      // Handshake cycle: the offered product must not be taken
      step_a(1'b1, 32'd6, 1'b1, 1'b1);
      chk("bp_hs_out_valid", 64'(a_out_valid), 64'd0);
      chk("bp_hs_in_ready",  64'(a_in_ready),  64'd1);
      chk("bp_hs_out_sum",   64'(a_out_sum),   64'd0);
      step_a(1'b1, 32'd6, 1'b1, 1'b1);
      chk("bp_next_out_valid", 64'(a_out_valid), 64'd1);
      chk("bp_next_out_sum",   64'(a_out_sum),   64'd6);
      chk("bp_next_out_count", 64'(a_out_count), 64'd1);
      step_a(1'b0, 32'd0, 1'b0, 1'b1);
      chk("bp_next_released", 64'(a_out_valid), 64'd0);

      // Overflow on the 33-bit instance
      step_b(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      step_b(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("ovf_mid_ovf", 64'(b_out_ovf), 64'd0);
      step_b(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk("ovf_out_valid", 64'(b_out_valid), 64'd1);
      chk("ovf_out_sum",   64'(b_out_sum),   exp_ovf_sum);
      chk("ovf_out_count", 64'(b_out_count), 64'd3);
      chk("ovf_out_ovf",   64'(b_out_ovf),   64'd1);
      step_b(1'b0, 32'd0, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(b_out_ovf), 64'd0);

      // Reset mid-frame after two accepts
      step_a(1'b1, 32'd5, 1'b0, 1'b0);
      step_a(1'b1, 32'd7, 1'b0, 1'b0);
      a_in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_a_idle("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      step_a(1'b0, 32'd0, 1'b0, 1'b0);
      chk("rst_no_stale_valid", 64'(a_out_valid), 64'd0);
      step_a(1'b1, 32'd3, 1'b0, 1'b1);
      step_a(1'b1, 32'd4, 1'b1, 1'b1);
      chk("rst_next_out_valid", 64'(a_out_valid), 64'd1);
      chk("rst_next_out_sum",   64'(a_out_sum),   64'd7);
      chk("rst_next_out_count", 64'(a_out_count), 64'd2);
      step_a(1'b0, 32'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prod_accum.md
# prod_accum

Downstream consumer of the 16x16 unsigned multiplier's 32-bit product. It accepts products over a valid/ready handshake and sums them into a wide accumulator. A frame closes after LEN products or an early `in_last`. The frame sum, product count and overflow flag are then presented on a second valid/ready handshake. This block is the accumulate stage of the pipelined MAC datapath.

## Interface
Parameters:
- `PROD_W`, 32, product width; matches the multiplier output.
- `ACC_W`, 40, accumulator width; must be ≥ PROD_W+1.
- `LEN`, 16, maximum products per frame; must be ≥ 1.
- `CNT_W`, $clog2(LEN+1), count width (derived, not overridden).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_prod` is valid.
- `in_ready` output 1: block can accept a product this cycle.
- `in_prod` input PROD_W: unsigned product from the multiplier.
- `in_last` input 1: qualified by `in_valid`; the current product closes the frame.
- `out_valid` output 1: frame result is valid.
- `out_ready` input 1: downstream takes the result.
- `out_sum` output ACC_W: frame sum.
- `out_count` output CNT_W: products in the frame, from 1 to LEN.
- `out_ovf` output 1: sticky flag; accumulator carry-out occurred during the frame.

## Operation
- FSM states: ACCUM and HOLD. Reset state is ACCUM.
- **ACCUM**
  - `in_ready`=1 and `out_valid`=0.
  - On accept (`in_valid & in_ready`): `acc <= acc + zero_ext(in_prod)` and `cnt <= cnt+1`.
  - Any carry out of bit ACC_W-1 sets `ovf`.
  - If `in_last`=1 or `cnt == LEN-1` at accept, go to HOLD. If both conditions hold in the same cycle, the frame closes once, with count LEN.
- **HOLD**
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`, `out_count` and `out_ovf` drive the registered `acc`, `cnt` and `ovf`. They stay stable until the handshake.
  - `in_valid`, `in_prod` and `in_last` are ignored.
  - On `out_ready`=1: clear `acc`, `cnt` and `ovf` to 0 and go to ACCUM.
  - There is no bypass. `in_ready` stays 0 in the handshake cycle, and the next product is accepted no earlier than the following cycle.
- Arithmetic:
  - Unsigned only. `in_prod` is zero-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W unless saturation is compiled in (see Configuration).
- Empty frames cannot occur, because a frame begins only with an accepted product.
- `in_last` without `in_valid` has no effect.
- An `rst` assertion at any point has these effects:
  - It immediately clears `acc`, `cnt`, `ovf` and the FSM.
  - Any partial frame or unconsumed result is discarded.
  - No output fires from a discarded frame.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
- Latency: `out_valid` rises 1 cycle after the closing product is accepted.
- Throughput: a frame of N products occupies at least N+1 cycles: N accept cycles plus ≥1 HOLD cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.
- Handshakes follow the AXI-stream rule: transfer occurs on any rising edge where valid and ready are both 1.

## Configuration
- Macro `PROD_ACCUM_SAT_EN`.
- Defined: on carry-out, `acc` saturates to all-ones (2^ACC_W−1) and stays there for the rest of the frame. `out_ovf`=1.
- Undefined: `acc` wraps modulo 2^ACC_W. `out_ovf`=1 still flags the wrap.
- The macro changes no other behaviour or timing.

## Test plan
- **Back-to-back frame:** LEN=4; products 1, 2, 3, 4 on consecutive cycles with `out_ready`=1 → `out_valid` the cycle after the 4th accept, `out_sum`=10, `out_count`=4, `out_ovf`=0.
- **Early close:** `in_last` on the 2nd product; products 0xFFFF_FFFF then 1 → `out_sum`=0x1_0000_0000, `out_count`=2, `out_ovf`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 → `in_ready`=0 throughout, and `out_sum`/`out_count` stay stable.
  - Raise `out_ready` → the next frame starts from `acc`=0, with its first accept one cycle after the handshake.
- **Overflow:** ACC_W=33, LEN=4; products 0xFFFF_FFFF ×3, `in_last` on the 3rd.
  - Macro undefined → `out_sum`=0x0_FFFF_FFFD, `out_ovf`=1.
  - Macro defined → `out_sum`=0x1_FFFF_FFFF, `out_ovf`=1.
- **Simultaneous close:** LEN=4; `in_last`=1 on the 4th product → exactly one result, `out_count`=4, with no extra or duplicated frame.
- **Reset mid-frame:**
  - Assert `rst` asynchronously after 2 accepts (5, 7) → all outputs go to their reset values immediately.
  - Next frame 3, 4 with `in_last` → `out_sum`=7, `out_count`=2.
